// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sequential divider core between NREQ
// requesters. One operation is in flight at a time. Zero divisors are answered
// locally without starting the core, and a watchdog aborts an operation whose
// core never reports done.
module div_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_q,
  output logic [W-1:0]      rsp_r,
  output logic              rsp_dz,
  output logic              rsp_to,
  output logic              div_start,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r,
  input  logic              div_done,
  input  logic              div_busy,
  output logic              arb_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [NREQ-1:0]  owner_oh;
  logic [7:0]       wait_cnt;

  logic             grant_found;
  logic [PW-1:0]    grant_idx;
  logic [NREQ-1:0]  grant_oh;

  // Index base+offs, wrapped into 0..NREQ-1 (offs is always below NREQ).
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Pick the first valid requester at or after rr_ptr; scanning from the far
  // end lets the nearest hit win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(rr_ptr, i);
      end
    end
    grant_oh = NREQ'(1) << grant_idx;
  end

  // Arbitration FSM with registered outputs; pulse outputs default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_oh  <= '0;
      wait_cnt  <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dz    <= 1'b0;
      rsp_to    <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      arb_busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every branch
      // below sees the values from before this edge.
      req_ready <= '0;
      rsp_valid <= '0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            req_ready <= grant_oh;
            div_a     <= req_a[grant_idx*W +: W];
            div_b     <= req_b[grant_idx*W +: W];
            owner_oh  <= grant_oh;
            rr_ptr    <= rr_index(grant_idx, 1);
            arb_busy  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A zero divisor is answered here; the core never sees a start.
          if (div_b == '0) begin
            rsp_valid <= owner_oh;
            rsp_q     <= '1;
            rsp_r     <= div_a;
            rsp_dz    <= 1'b1;
            rsp_to    <= 1'b0;
            state     <= RESP;
          end else if (!div_busy) begin
            div_start <= 1'b1;
            wait_cnt  <= 8'd1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (div_done) begin
            rsp_valid <= owner_oh;
            rsp_q     <= div_q;
            rsp_r     <= div_r;
            rsp_dz    <= 1'b0;
            rsp_to    <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == 8'(TIMEOUT)) begin
            rsp_valid <= owner_oh;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dz    <= 1'b0;
            rsp_to    <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          // rsp_valid is high during this cycle; rsp_* keep their values afterwards.
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural divider core, scoreboard of
// expected responses, a vector table and hand-written corner sequences.
module tb_div_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int TO   = 16;
  localparam int LAT  = 5;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_q, rsp_r;
  logic              rsp_dz, rsp_to;
  logic              div_start;
  logic [W-1:0]      div_a, div_b;
  logic [W-1:0]      div_q = '0;
  logic [W-1:0]      div_r = '0;
  logic              div_done, div_busy;
  logic              arb_busy;

  div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_to(rsp_to),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_done(div_done), .div_busy(div_busy),
    .arb_busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider core: fixed latency, can be told to hang.
  logic       core_busy, core_done, core_hang, stray_done;
  int         core_cnt;
  logic [W-1:0] qa, qb;
  assign div_busy = core_busy;
  assign div_done = core_done | stray_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else begin
      core_done <= 1'b0;
      if (div_start && !core_hang) begin
        core_busy <= 1'b1;
        core_cnt  <= LAT;
        qa        <= div_a;
        qb        <= div_b;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_busy <= 1'b0;
          core_done <= 1'b1;
          div_q     <= (qb != 0) ? qa / qb : '0;
          div_r     <= (qb != 0) ? qa % qb : '0;
        end
        core_cnt <= core_cnt - 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] own;
    logic [W-1:0]    q;
    logic [W-1:0]    r;
    logic            dz;
    logic            to;
  } exp_t;

  exp_t sb[$];

  int start_count = 0;
  int start_cyc   = -1;
  int done_cyc    = -1;
  int rsp_cyc     = -1;

  // Monitor: samples on the falling edge and checks every response against the scoreboard.
  always @(negedge clk) begin
    if (div_start) begin
      start_count++;
      start_cyc = cyc;
    end
    if (div_done) done_cyc = cyc;
    if (rsp_valid != '0) begin
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'(e.own));
        check("rsp_qr", 64'({rsp_q, rsp_r}), 64'({e.q, e.r}));
        check("rsp_flags", 64'({rsp_dz, rsp_to}), 64'({e.dz, e.to}));
      end
    end
  end

  task automatic push_exp(input int idx, input logic [W-1:0] q, r, input logic dz, to);
    exp_t e;
    logic [NREQ-1:0] one;
    one   = 1;
    e.own = one << idx;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.to  = to;
    sb.push_back(e);
  endtask

  // Raise a single request, wait (bounded) for its accept pulse, then drop it.
  task automatic do_req(input int idx, input logic [W-1:0] a, b, input logic push,
                        input logic [W-1:0] q, r, input logic dz, to, output int t);
    if (push) push_exp(idx, q, r, dz, to);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
    t = -1;
    for (int n = 0; n < 100 && t < 0; n++) begin
      @(negedge clk);
      if (req_ready[idx]) t = cyc;
    end
    req_valid[idx] = 1'b0;
    if (t < 0) check("accept_timeout", 64'(req_ready), 64'(1) << idx);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200 && (sb.size() != 0 || arb_busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  typedef struct {
    int         idx;
    logic [W-1:0] a, b, q, r;
    logic       dz;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t, sc0, gn, raised, n_after, r1_pos;
    logic [NREQ-1:0] order[2];

    vecs[0] = '{idx: 0, a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
    vecs[1] = '{idx: 1, a: 8'd7,   b: 8'd9,   q: 8'd0,   r: 8'd7,   dz: 1'b0};
    vecs[2] = '{idx: 0, a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
    vecs[3] = '{idx: 1, a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200, dz: 1'b1};
    vecs[4] = '{idx: 0, a: 8'd128, b: 8'd128, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[5] = '{idx: 1, a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15,  dz: 1'b0};

    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    core_hang  = 1'b0;
    stray_done = 1'b0;
    reset      = 1'b0;
    #1 reset   = 1'b1;
    #2;
    check("reset_outputs",
          64'({req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_to, div_start, div_a, div_b, arb_busy}),
          64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Both requesters in the same cycle with rr_ptr at 0: r0 first, then r1.
    push_exp(0, 8'd10, 8'd0, 1'b0, 1'b0);
    push_exp(1, 8'd2, 8'd1, 1'b0, 1'b0);
    req_a = {8'd9, 8'd50};
    req_b = {8'd4, 8'd5};
    req_valid = 2'b11;
    order[0] = '0;
    order[1] = '0;
    gn = 0;
    for (int n = 0; n < 100 && gn < 2; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        order[gn] = req_ready;
        gn++;
        req_valid = req_valid & ~req_ready;
      end
    end
    req_valid = '0;
    check("simul_first_grant", 64'(order[0]), 64'b01);
    check("simul_second_grant", 64'(order[1]), 64'b10);
    wait_idle();

    // Single request with latency checks.
    sc0 = start_count;
    do_req(0, 8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, 1'b0, t);
    wait_idle();
    check("start_latency", 64'(start_cyc), 64'(t + 1));
    check("start_pulses", 64'(start_count - sc0), 64'd1);
    check("rsp_after_done", 64'(rsp_cyc), 64'(done_cyc + 1));
    repeat (3) @(negedge clk);
    check("rsp_hold", 64'({rsp_q, rsp_r}), 64'({8'd14, 8'd2}));

    // Divide by zero: no core start, response one cycle after accept.
    sc0 = start_count;
    do_req(1, 8'd33, 8'd0, 1'b1, 8'd255, 8'd33, 1'b1, 1'b0, t);
    wait_idle();
    check("dz_latency", 64'(rsp_cyc), 64'(t + 1));
    check("dz_no_start", 64'(start_count - sc0), 64'd0);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      do_req(vecs[i].idx, vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0, t);
      wait_idle();
    end

    // A done pulse while idle must not produce a response.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("stray_done_ignored", 64'({rsp_valid, arb_busy}), 64'd0);
    end

    // Watchdog: hung core, then a normal operation.
    core_hang = 1'b1;
    do_req(0, 8'd20, 8'd3, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1, t);
    wait_idle();
    check("timeout_latency", 64'(rsp_cyc), 64'(start_cyc + TO));
    core_hang = 1'b0;
    do_req(1, 8'd60, 8'd7, 1'b1, 8'd8, 8'd4, 1'b0, 1'b0, t);
    wait_idle();

    // Fairness: r0 held continuously, r1 raised right after an r0 grant.
    req_a[0 +: W] = 8'd10;
    req_b[0 +: W] = 8'd2;
    req_valid[0]  = 1'b1;
    raised  = 0;
    n_after = 0;
    r1_pos  = 0;
    for (int n = 0; n < 300 && r1_pos == 0; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        if (req_ready[0]) push_exp(0, 8'd5, 8'd0, 1'b0, 1'b0);
        if (raised != 0) n_after++;
        if (req_ready[1]) begin
          push_exp(1, 8'd1, 8'd0, 1'b0, 1'b0);
          req_valid = '0;
          r1_pos = n_after;
        end else if (raised == 0 && req_ready[0]) begin
          raised = 1;
          req_a[W +: W] = 8'd7;
          req_b[W +: W] = 8'd7;
          req_valid[1]  = 1'b1;
        end
      end
    end
    req_valid = '0;
    check("fair_r1_within_2", 64'(r1_pos >= 1 && r1_pos <= 2), 64'd1);
    wait_idle();

    // Reset while waiting on the core drops the operation silently.
    core_hang = 1'b1;
    do_req(0, 8'd50, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, t);
    repeat (3) @(negedge clk);
    check("busy_in_wait", 64'(arb_busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_in_wait_outputs",
          64'({req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_to, div_start, div_a, div_b, arb_busy}),
          64'd0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    core_hang = 1'b0;
    repeat (5) @(negedge clk);
    do_req(0, 8'd8, 8'd2, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0, t);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
